// File: rtl/fetch_bp_pkg.sv
// fetch_bp_pkg: shared definitions for the fetch stage and its branch predictor.
//   RESET_PC_DEF / *_IDX_BITS_DEF : default parameter values
//   bht_cnt_e                     : 2-bit saturating counter encodings
//   NOP                           : instruction word forwarded while in reset
//   sat_cnt_next()                : saturating counter step used for training
package fetch_bp_pkg;

  localparam logic [31:0] RESET_PC_DEF     = 32'hBFC0_0000;
  localparam int          BHT_IDX_BITS_DEF = 6;
  localparam int          BTB_IDX_BITS_DEF = 4;

  typedef enum logic [1:0] {
    SNT = 2'b00,  // strongly not-taken
    WNT = 2'b01,  // weakly not-taken (reset value)
    WT  = 2'b10,  // weakly taken
    ST  = 2'b11   // strongly taken
  } bht_cnt_e;

  localparam logic [31:0] NOP = 32'h0000_0000;

  // Step a 2-bit counter toward the observed outcome, clamping at SNT/ST.
  function automatic logic [1:0] sat_cnt_next(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    nxt = cnt;
    if (taken) begin
      if (cnt != ST) nxt = cnt + 2'd1;
    end else begin
      if (cnt != SNT) nxt = cnt - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/fetch_bp_branch_predictor.sv
// branch_predictor: 2-bit-counter BHT plus direct-mapped BTB.
//   clk, rst_n        : clock, asynchronous active-low reset
//   lookup_pc         : PC being fetched this cycle
//   lookup_cnt        : BHT counter for lookup_pc (pre-update value)
//   lookup_hit        : BTB entry valid and tag matches lookup_pc
//   lookup_target     : BTB target for lookup_pc's index
//   upd_valid         : training strobe (single-cycle valid, no ready: the
//                       predictor always accepts an update in the cycle it is
//                       presented, there is no back-pressure)
//   upd_pc/upd_taken/upd_target : resolved branch PC, outcome and target
module branch_predictor
  import fetch_bp_pkg::*;
#(
  parameter int BHT_IDX_BITS = BHT_IDX_BITS_DEF,
  parameter int BTB_IDX_BITS = BTB_IDX_BITS_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] lookup_pc,
  output logic [1:0]  lookup_cnt,
  output logic        lookup_hit,
  output logic [31:0] lookup_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target
);

  localparam int BHT_N = 1 << BHT_IDX_BITS;
  localparam int BTB_N = 1 << BTB_IDX_BITS;
  localparam int TAG_W = 30 - BTB_IDX_BITS;

  logic [1:0]       bht_q       [BHT_N];
  logic [1:0]       bht_d       [BHT_N];
  logic [BTB_N-1:0] btb_valid_q;
  logic [BTB_N-1:0] btb_valid_d;
  logic [TAG_W-1:0] btb_tag_q   [BTB_N];
  logic [TAG_W-1:0] btb_tag_d   [BTB_N];
  logic [31:0]      btb_tgt_q   [BTB_N];
  logic [31:0]      btb_tgt_d   [BTB_N];

  logic [BHT_IDX_BITS-1:0] lk_bht_idx;
  logic [BTB_IDX_BITS-1:0] lk_btb_idx;
  logic [TAG_W-1:0]        lk_tag;
  logic [BHT_IDX_BITS-1:0] up_bht_idx;
  logic [BTB_IDX_BITS-1:0] up_btb_idx;
  logic [TAG_W-1:0]        up_tag;

  // Instructions are word aligned, so the byte-offset bits carry no information.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{lookup_pc[1:0], upd_pc[1:0]};

  assign lk_bht_idx = lookup_pc[BHT_IDX_BITS+1:2];
  assign lk_btb_idx = lookup_pc[BTB_IDX_BITS+1:2];
  assign lk_tag     = lookup_pc[31:BTB_IDX_BITS+2];
  assign up_bht_idx = upd_pc[BHT_IDX_BITS+1:2];
  assign up_btb_idx = upd_pc[BTB_IDX_BITS+1:2];
  assign up_tag     = upd_pc[31:BTB_IDX_BITS+2];

  // Lookup reads the registered arrays, so a same-cycle update to the same
  // entry is seen only from the following cycle.
  assign lookup_cnt    = bht_q[lk_bht_idx];
  assign lookup_hit    = btb_valid_q[lk_btb_idx] && (btb_tag_q[lk_btb_idx] == lk_tag);
  assign lookup_target = btb_tgt_q[lk_btb_idx];

  always_comb begin
    bht_d       = bht_q;
    btb_valid_d = btb_valid_q;
    btb_tag_d   = btb_tag_q;
    btb_tgt_d   = btb_tgt_q;
    if (upd_valid) begin
      bht_d[up_bht_idx] = sat_cnt_next(bht_q[up_bht_idx], upd_taken);
      // Only taken branches teach the BTB a target.
      if (upd_taken) begin
        btb_valid_d[up_btb_idx] = 1'b1;
        btb_tag_d[up_btb_idx]   = up_tag;
        btb_tgt_d[up_btb_idx]   = upd_target;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_N; i++) bht_q[i] <= WNT;
      btb_valid_q <= '0;
    end else begin
      bht_q       <= bht_d;
      btb_valid_q <= btb_valid_d;
    end
  end

  // Tag/target payload needs no reset: an entry is ignored until its valid bit is set.
  always_ff @(posedge clk) begin
    btb_tag_q <= btb_tag_d;
    btb_tgt_q <= btb_tgt_d;
  end

endmodule

// File: rtl/fetch_bp.sv
// fetch_bp: instruction fetch stage with BHT/BTB next-PC prediction.
//   CLK, RESET             : clock, asynchronous active-low reset
//   STALL                  : hold PC (training still applies)
//   FLUSH, Redirect_Addr   : redirect PC; overrides STALL and prediction
//   Instr_address_2IM      : fetch address (= PC)
//   Instr1_fIM             : instruction word returned combinationally
//   Instr1_OUT             : fetched word (NOP while in reset)
//   Instr_PC_OUT           : PC of fetched word
//   Instr_PC_Plus4         : PC + 4 (wraps modulo 2^32)
//   Branch_prediction_OUT  : predicted taken (BTB hit and counter MSB)
//   Branch_predictions_OUT : BHT counter used for the prediction
//   Update_*               : training port from the resolve stage
module fetch_bp
  import fetch_bp_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = RESET_PC_DEF,
  parameter int          BHT_IDX_BITS = BHT_IDX_BITS_DEF,
  parameter int          BTB_IDX_BITS = BTB_IDX_BITS_DEF
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        STALL,
  input  logic        FLUSH,
  input  logic [31:0] Redirect_Addr,
  output logic [31:0] Instr_address_2IM,
  input  logic [31:0] Instr1_fIM,
  output logic [31:0] Instr1_OUT,
  output logic [31:0] Instr_PC_OUT,
  output logic [31:0] Instr_PC_Plus4,
  output logic        Branch_prediction_OUT,
  output logic [1:0]  Branch_predictions_OUT,
  input  logic        Update_valid,
  input  logic [31:0] Update_PC,
  input  logic        Update_taken,
  input  logic [31:0] Update_target
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4;
  logic [1:0]  bp_cnt;
  logic        bp_hit;
  logic [31:0] bp_target;
  logic        pred_taken;

  branch_predictor #(
    .BHT_IDX_BITS (BHT_IDX_BITS),
    .BTB_IDX_BITS (BTB_IDX_BITS)
  ) u_bp (
    .clk           (CLK),
    .rst_n         (RESET),
    .lookup_pc     (pc_q),
    .lookup_cnt    (bp_cnt),
    .lookup_hit    (bp_hit),
    .lookup_target (bp_target),
    .upd_valid     (Update_valid),
    .upd_pc        (Update_PC),
    .upd_taken     (Update_taken),
    .upd_target    (Update_target)
  );

  assign pc_plus4   = pc_q + 32'd4;
  assign pred_taken = bp_hit && bp_cnt[1];

  always_comb begin
    pc_d = pc_plus4;
    if (FLUSH)           pc_d = Redirect_Addr;
    else if (STALL)      pc_d = pc_q;
    else if (pred_taken) pc_d = bp_target;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  // Outputs are combinational; the IF/ID register downstream is the pipeline
  // boundary. While reset is held, a NOP and a not-taken prediction are
  // forced so nothing fetched during reset can look like a live instruction.
  always_comb begin
    Instr_address_2IM      = pc_q;
    Instr_PC_OUT           = pc_q;
    Instr_PC_Plus4         = pc_plus4;
    Instr1_OUT             = RESET ? Instr1_fIM : NOP;
    Branch_prediction_OUT  = RESET && pred_taken;
    Branch_predictions_OUT = RESET ? bp_cnt : WNT;
  end

endmodule
